scoreboard_regfile: RTL and testbench

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 60 ++++++
 rtl/scoreboard_regfile.sv | 74 +++++++
 tb/tb_scoreboard_regfile.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and the index type for the scoreboarded register file.
package regfile_pkg;

  localparam int RF_WIDTH_DEF = 16;
  localparam int RF_DEPTH_DEF = 8;

  typedef logic [$clog2(RF_DEPTH_DEF)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, source busy
// flags with optional writeback forwarding, stall, and a running busy count.
module regfile_scoreboard #(
  parameter int DEPTH  = 8,
  parameter int BYPASS = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         ld_i,
  input  logic [$clog2(DEPTH)-1:0]     dr_i,
  input  logic                         issue_i,
  input  logic [$clog2(DEPTH)-1:0]     issue_dr_i,
  input  logic [$clog2(DEPTH)-1:0]     sr1_i,
  input  logic [$clog2(DEPTH)-1:0]     sr2_i,
  input  logic                         use1_i,
  input  logic                         use2_i,
  output logic                         sr1_busy_o,
  output logic                         sr2_busy_o,
  output logic                         stall_o,
  output logic [$clog2(DEPTH+1)-1:0]   busy_count_o
);

  localparam int   CW  = $clog2(DEPTH + 1);
  localparam logic BYP = (BYPASS != 0);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             set_new, clr_eff;

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (ld_i)    busy_d[dr_i]       = 1'b0;
    if (issue_i) busy_d[issue_dr_i] = 1'b1;
  end

  always_comb begin
    set_new = issue_i & ~busy_q[issue_dr_i];
    clr_eff = ld_i & busy_q[dr_i] & ~(issue_i & (issue_dr_i == dr_i));
    cnt_d   = cnt_q + CW'(set_new) - CW'(clr_eff);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    sr1_busy_o   = busy_q[sr1_i] & ~(BYP & ld_i & (dr_i == sr1_i));
    sr2_busy_o   = busy_q[sr2_i] & ~(BYP & ld_i & (dr_i == sr2_i));
    stall_o      = (use1_i & sr1_busy_o) | (use2_i & sr2_busy_o);
    busy_count_o = cnt_q;
  end

endmodule

// File: rtl/scoreboard_regfile.sv
// Two-read, one-write register file with a writeback scoreboard and
// optional same-cycle write-to-read forwarding.
module scoreboard_regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH_DEF,
  parameter int DEPTH  = RF_DEPTH_DEF,
  parameter int BYPASS = 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         LD_REG,
  input  logic [$clog2(DEPTH)-1:0]     DR,
  input  logic [WIDTH-1:0]             In,
  input  logic                         Issue,
  input  logic [$clog2(DEPTH)-1:0]     Issue_DR,
  input  logic [$clog2(DEPTH)-1:0]     SR1,
  input  logic [$clog2(DEPTH)-1:0]     SR2,
  input  logic                         Use1,
  input  logic                         Use2,
  output logic [WIDTH-1:0]             SR1_Out,
  output logic [WIDTH-1:0]             SR2_Out,
  output logic                         SR1_Busy,
  output logic                         SR2_Busy,
  output logic                         Stall,
  output logic [$clog2(DEPTH+1)-1:0]   Busy_Count
);

  localparam int   AW  = $clog2(DEPTH);
  localparam int   CW  = $clog2(DEPTH + 1);
  localparam logic BYP = (BYPASS != 0);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [AW-1:0]    sr1_idx, sr2_idx;
  logic [CW-1:0]    busy_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (LD_REG) begin
      regs_q[DR] <= In;
    end
  end

  always_comb begin
    sr1_idx = SR1;
    sr2_idx = SR2;
    SR1_Out = (BYP && LD_REG && (DR == sr1_idx)) ? In : regs_q[sr1_idx];
    SR2_Out = (BYP && LD_REG && (DR == sr2_idx)) ? In : regs_q[sr2_idx];
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk_i        (Clk),
    .rst_ni       (Reset),
    .ld_i         (LD_REG),
    .dr_i         (DR),
    .issue_i      (Issue),
    .issue_dr_i   (Issue_DR),
    .sr1_i        (SR1),
    .sr2_i        (SR2),
    .use1_i       (Use1),
    .use2_i       (Use2),
    .sr1_busy_o   (SR1_Busy),
    .sr2_busy_o   (SR2_Busy),
    .stall_o      (Stall),
    .busy_count_o (busy_cnt)
  );

  assign Busy_Count = busy_cnt;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Bench driving a forwarding and a non-forwarding instance with the same
// stimulus, checked every cycle against an array-based reference model.
module tb_scoreboard_regfile;
  import regfile_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, LD_REG, Issue, Use1, Use2;
  reg_idx_t    DR, Issue_DR, SR1, SR2;
  logic [15:0] In;

  logic [15:0] b_o1, b_o2, n_o1, n_o2;
  logic        b_bz1, b_bz2, b_st, n_bz1, n_bz2, n_st;
  logic [3:0]  b_cnt, n_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [15:0] mreg  [8];
  bit          mbusy [8];

  always #5 Clk = ~Clk;

  scoreboard_regfile #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) u_byp (
    .Clk(Clk), .Reset(Reset), .LD_REG(LD_REG), .DR(DR), .In(In),
    .Issue(Issue), .Issue_DR(Issue_DR), .SR1(SR1), .SR2(SR2),
    .Use1(Use1), .Use2(Use2), .SR1_Out(b_o1), .SR2_Out(b_o2),
    .SR1_Busy(b_bz1), .SR2_Busy(b_bz2), .Stall(b_st), .Busy_Count(b_cnt));

  scoreboard_regfile #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) u_nob (
    .Clk(Clk), .Reset(Reset), .LD_REG(LD_REG), .DR(DR), .In(In),
    .Issue(Issue), .Issue_DR(Issue_DR), .SR1(SR1), .SR2(SR2),
    .Use1(Use1), .Use2(Use2), .SR1_Out(n_o1), .SR2_Out(n_o2),
    .SR1_Busy(n_bz1), .SR2_Busy(n_bz2), .Stall(n_st), .Busy_Count(n_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state update
  always @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < 8; i++) begin mreg[i] = '0; mbusy[i] = 1'b0; end
    end else begin
      if (LD_REG) begin mreg[DR] = In; mbusy[DR] = 1'b0; end
      if (Issue) mbusy[Issue_DR] = 1'b1;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge Clk) begin
    if (chk_en) begin
      logic [15:0] e1, e2;
      bit eb1, eb2, nb1, nb2;
      int pop;
      pop = 0;
      for (int i = 0; i < 8; i++) pop += mbusy[i] ? 1 : 0;
      e1  = (LD_REG && DR == SR1) ? In : mreg[SR1];
      e2  = (LD_REG && DR == SR2) ? In : mreg[SR2];
      eb1 = mbusy[SR1] && !(LD_REG && DR == SR1);
      eb2 = mbusy[SR2] && !(LD_REG && DR == SR2);
      nb1 = mbusy[SR1];
      nb2 = mbusy[SR2];
      chk("byp_sr1_out", 32'(b_o1), 32'(e1));
      chk("byp_sr2_out", 32'(b_o2), 32'(e2));
      chk("byp_sr1_busy", 32'(b_bz1), 32'(eb1));
      chk("byp_sr2_busy", 32'(b_bz2), 32'(eb2));
      chk("byp_stall", 32'(b_st), 32'((Use1 && eb1) || (Use2 && eb2)));
      chk("byp_count", 32'(b_cnt), 32'(pop));
      chk("nob_sr1_out", 32'(n_o1), 32'(mreg[SR1]));
      chk("nob_sr2_out", 32'(n_o2), 32'(mreg[SR2]));
      chk("nob_sr1_busy", 32'(n_bz1), 32'(nb1));
      chk("nob_sr2_busy", 32'(n_bz2), 32'(nb2));
      chk("nob_stall", 32'(n_st), 32'((Use1 && nb1) || (Use2 && nb2)));
      chk("nob_count", 32'(n_cnt), 32'(pop));
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    LD_REG = 0; Issue = 0; Use1 = 0; Use2 = 0;
  endtask

  initial begin
    Reset = 0; idle(); DR = '0; Issue_DR = '0; SR1 = '0; SR2 = '0; In = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    @(negedge Clk);
    chk("rst_sr1_out", 32'(b_o1), 32'h0);
    chk("rst_count", 32'(b_cnt), 32'h0);
    Reset = 1;

    // write then read
    LD_REG = 1; DR = 3; In = 16'hCAFE; cyc();
    idle(); SR1 = 3; SR2 = 0;
    @(negedge Clk);
    chk("wr_rd_sr1", 32'(b_o1), 32'hCAFE);
    chk("wr_rd_sr2", 32'(b_o2), 32'h0000);
    chk("wr_rd_nob_sr1", 32'(n_o1), 32'hCAFE);
    cyc();

    // forwarding with R2 pending
    Issue = 1; Issue_DR = 2; cyc();
    idle(); LD_REG = 1; DR = 2; In = 16'hBEEF; SR1 = 2; SR2 = 2; Use1 = 1;
    @(negedge Clk);
    chk("byp_both1", 32'(b_o1), 32'hBEEF);
    chk("byp_both2", 32'(b_o2), 32'hBEEF);
    chk("byp_busy0", 32'(b_bz1), 32'h0);
    chk("nob_old1", 32'(n_o1), 32'h0000);
    chk("nob_old2", 32'(n_o2), 32'h0000);
    chk("nob_busy1", 32'(n_bz1), 32'h1);
    cyc(); idle();

    // stall on pending R5
    Issue = 1; Issue_DR = 5; cyc();
    idle(); SR1 = 5; Use1 = 1;
    @(negedge Clk);
    chk("stall_set", 32'(b_st), 32'h1);
    chk("stall_cnt1", 32'(b_cnt), 32'h1);
    cyc();
    LD_REG = 1; DR = 5; In = 16'h0055;
    @(negedge Clk);
    chk("stall_byp_clear", 32'(b_st), 32'h0);
    chk("stall_nob_hold", 32'(n_st), 32'h1);
    cyc(); idle();
    @(negedge Clk);
    chk("stall_cnt0", 32'(b_cnt), 32'h0);

    // collision on R4
    Issue = 1; Issue_DR = 4; cyc();
    LD_REG = 1; DR = 4; In = 16'h1234;
    @(negedge Clk);
    chk("coll_cnt_before", 32'(b_cnt), 32'h1);
    cyc(); idle(); SR1 = 4;
    @(negedge Clk);
    chk("coll_data", 32'(n_o1), 32'h1234);
    chk("coll_busy", 32'(n_bz1), 32'h1);
    chk("coll_cnt", 32'(b_cnt), 32'h1);
    LD_REG = 1; DR = 4; In = 16'h1234; cyc(); idle();

    // fill all eight
    for (int i = 0; i < 8; i++) begin Issue = 1; Issue_DR = reg_idx_t'(i); cyc(); end
    @(negedge Clk);
    chk("fill_cnt8", 32'(b_cnt), 32'h8);
    Issue_DR = 0; cyc(); idle();
    @(negedge Clk);
    chk("fill_repeat_cnt8", 32'(b_cnt), 32'h8);

    // reset mid-operation
    Reset = 0; cyc(); Reset = 1;
    for (int i = 1; i <= 3; i++) begin Issue = 1; Issue_DR = reg_idx_t'(i); cyc(); end
    idle(); LD_REG = 1; DR = 7; In = 16'hFFFF; cyc(); idle();
    SR1 = 7; SR2 = 1; Use1 = 1; Use2 = 1;
    @(negedge Clk);
    chk("pre_rst_r7", 32'(b_o1), 32'hFFFF);
    chk("pre_rst_cnt", 32'(b_cnt), 32'h3);
    Reset = 0; cyc();
    @(negedge Clk);
    chk("rst_mid_out1", 32'(b_o1), 32'h0);
    chk("rst_mid_busy2", 32'(b_bz2), 32'h0);
    chk("rst_mid_stall", 32'(b_st), 32'h0);
    chk("rst_mid_cnt", 32'(b_cnt), 32'h0);
    Reset = 1; cyc();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      Reset    = ($urandom_range(0, 79) != 0);
      LD_REG   = Reset && ($urandom_range(0, 1) != 0);
      Issue    = ($urandom_range(0, 2) != 0);
      DR       = reg_idx_t'($urandom_range(0, 7));
      Issue_DR = ($urandom_range(0, 5) == 0) ? DR : reg_idx_t'($urandom_range(0, 7));
      SR1      = ($urandom_range(0, 3) == 0) ? DR : reg_idx_t'($urandom_range(0, 7));
      SR2      = ($urandom_range(0, 3) == 0) ? DR : reg_idx_t'($urandom_range(0, 7));
      Use1     = $urandom_range(0, 1) != 0;
      Use2     = $urandom_range(0, 1) != 0;
      In       = 16'($urandom);
      cyc();
    end
    idle(); Reset = 1;
    @(negedge Clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
